pulse_activity_meter: RTL and testbench

- Sits directly downstream of the counter block and consumes its pulse2/pulse4/pulse8/pulse16 outputs.
- Counts toggles (both edges) on each of four pulse inputs over a fixed measurement window of WINDOW clock cycles.
- At each window end, snapshots the four counts and presents them on a valid/ready output port.
- Gives a hardware cross-check of per-signal activity against the toggle counts derived from the VCD trace.

---
 rtl/pulse_activity_meter.sv | 110 +++++++++++
 tb/tb_pulse_activity_meter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_activity_meter.sv
// Windowed toggle counter for the four counter pulse outputs: counts both edges
// per channel over WINDOW cycles and hands each window's snapshot out over valid/ready.
module pulse_activity_meter #(
  parameter int WINDOW = 64,
  parameter int CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [3:0]           pulse_in,
  output logic [4*CNT_W-1:0]   out_counts,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overrun,
  output logic [15:0]          window_id
);

  localparam int WCNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic {IDLE = 1'b0, MEASURE = 1'b1} state_t;

  // Handshake: a snapshot transfers on any cycle with out_valid=1 and out_ready=1;
  // out_valid only drops after a transfer, and only an overrun replaces unaccepted data.
  state_t                    state, state_nxt;
  logic [3:0]                prev;
  logic [3:0]                tog;
  logic [WCNT_W-1:0]         wcnt;
  logic [3:0][CNT_W-1:0]     acc;
  logic [3:0][CNT_W-1:0]     acc_nxt;
  logic                      start;
  logic                      run;
  logic                      snap;
  logic                      xfer;

  assign tog = pulse_in ^ prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en)  state_nxt = MEASURE;
      MEASURE: if (!en) state_nxt = IDLE;
      default:          state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start = 1'b0;
    run   = 1'b0;
    snap  = 1'b0;
    case (state)
      IDLE:    start = en;
      MEASURE: begin
        run  = en;
        snap = en && (wcnt == WCNT_LAST);
      end
      default: ;
    endcase
    xfer = out_valid && out_ready;
  end

  // Saturating increment: a full accumulator absorbs further toggles.
  always_comb begin
    acc_nxt = acc;
    for (int i = 0; i < 4; i++) begin
      if (acc[i] != CNT_MAX) acc_nxt[i] = acc[i] + CNT_W'(tog[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev       <= '0;
      wcnt       <= '0;
      acc        <= '0;
      out_counts <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
      window_id  <= '0;
    end else begin
      prev <= pulse_in;

      // Leaving MEASURE (or sitting in IDLE) discards the partial window.
      if (run && !snap) begin
        acc  <= acc_nxt;
        wcnt <= wcnt + WCNT_W'(1);
      end else begin
        acc  <= '0;
        wcnt <= '0;
      end

      if (start)     window_id <= '0;
      else if (snap) window_id <= window_id + 16'd1;

      if (snap) out_counts <= acc_nxt;

      if (snap)      out_valid <= 1'b1;
      else if (xfer) out_valid <= 1'b0;

      if (start)                                  overrun <= 1'b0;
      else if (snap && out_valid && !out_ready)   overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pulse_activity_meter.sv
// Bench for pulse_activity_meter: two instances (CNT_W=8 and CNT_W=4) share stimulus
// and are checked against a window-level toggle model through expected-snapshot queues.
module tb_pulse_activity_meter;

  localparam int WINDOW = 64;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        out_ready = 1'b0;
  logic [3:0]  pulse_in = 4'd0;

  logic [31:0] counts_a;
  logic        valid_a, ovr_a;
  logic [15:0] wid_a;
  logic [15:0] counts_b;
  logic        valid_b, ovr_b;
  logic [15:0] wid_b;

  always #5 clk = ~clk;

  pulse_activity_meter #(.WINDOW(WINDOW), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .pulse_in(pulse_in),
    .out_counts(counts_a), .out_valid(valid_a), .out_ready(out_ready),
    .overrun(ovr_a), .window_id(wid_a)
  );

  pulse_activity_meter #(.WINDOW(WINDOW), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .pulse_in(pulse_in),
    .out_counts(counts_b), .out_valid(valid_b), .out_ready(out_ready),
    .overrun(ovr_b), .window_id(wid_b)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [47:0] exp_q_a[$];
  logic [31:0] exp_q_b[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // ---------------- reference model ----------------
  // Works on whole windows: tally every sample-to-sample change, clamp only at the end.
  logic [3:0]  m_prev = 4'd0;
  bit          m_act = 1'b0;
  bit          m_pend = 1'b0;
  bit          m_ovr = 1'b0;
  int          m_n = 0;
  int          m_cnt[4] = '{0, 0, 0, 0};
  logic [15:0] m_wid = 16'd0;

  always @(posedge clk) begin
    logic [3:0] t;
    bit         accept;
    bit         snapped;
    if (!rst_n) begin
      m_prev = 4'd0; m_act = 0; m_pend = 0; m_ovr = 0; m_n = 0; m_wid = 16'd0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
      exp_q_a.delete();
      exp_q_b.delete();
    end else begin
      accept  = m_pend && out_ready;
      t       = pulse_in ^ m_prev;
      m_prev  = pulse_in;
      snapped = 0;
      if (!m_act) begin
        if (en) begin
          m_act = 1; m_wid = 16'd0; m_ovr = 0; m_n = 0;
          foreach (m_cnt[i]) m_cnt[i] = 0;
        end
      end else if (!en) begin
        m_act = 0;
      end else begin
        foreach (m_cnt[i]) m_cnt[i] += int'(t[i]);
        m_n++;
        if (m_n == WINDOW) begin
          snapped = 1;
          m_wid = m_wid + 16'd1;
          exp_q_a.push_back({m_wid, 8'(sat(m_cnt[3], 255)), 8'(sat(m_cnt[2], 255)),
                             8'(sat(m_cnt[1], 255)), 8'(sat(m_cnt[0], 255))});
          exp_q_b.push_back({m_wid, 4'(sat(m_cnt[3], 15)), 4'(sat(m_cnt[2], 15)),
                             4'(sat(m_cnt[1], 15)), 4'(sat(m_cnt[0], 15))});
          m_n = 0;
          foreach (m_cnt[i]) m_cnt[i] = 0;
        end
      end
      if (snapped) begin
        if (m_pend && !accept) m_ovr = 1;
        m_pend = 1;
      end else if (accept) begin
        m_pend = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  logic [15:0] last_a = 16'd0;
  logic [15:0] last_b = 16'd0;

  always @(negedge clk) begin
    if (!rst_n) begin
      last_a = 16'd0;
      last_b = 16'd0;
    end else begin
      check("valid_a", 64'(valid_a), 64'(m_pend));
      check("valid_b", 64'(valid_b), 64'(m_pend));
      check("overrun_a", 64'(ovr_a), 64'(m_ovr));
      check("overrun_b", 64'(ovr_b), 64'(m_ovr));
      check("window_id_a", 64'(wid_a), 64'(m_wid));
      if (wid_a != last_a && wid_a != 16'd0) begin
        if (exp_q_a.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL snap_a_unexpected: got %0h expected none", {wid_a, counts_a});
        end else check("snap_a", 64'({wid_a, counts_a}), 64'(exp_q_a.pop_front()));
      end
      if (wid_b != last_b && wid_b != 16'd0) begin
        if (exp_q_b.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL snap_b_unexpected: got %0h expected none", {wid_b, counts_b});
        end else check("snap_b", 64'({wid_b, counts_b}), 64'(exp_q_b.pop_front()));
      end
      last_a = wid_a;
      last_b = wid_b;
    end
  end

  // ---------------- driver tasks ----------------
  logic [15:0] ctr = 16'd0;
  bit use_ctr = 1'b1;
  bit rnd_ready = 1'b0;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      ctr = ctr + 16'd1;
      pulse_in = use_ctr ? ctr[3:0] : 4'($urandom_range(0, 15));
      if (rnd_ready) out_ready = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic wait_n(input int target);
    int k;
    for (k = 0; k < 200 && !(m_act && m_n == target); k++) tick(1);
    if (!(m_act && m_n == target)) begin
      n_tests++; n_fail++;
      $display("FAIL wait_window_pos: got %0d expected %0d", m_n, target);
    end
  endtask

  task automatic check_nominal(input string tag);
    check({tag, "_counts_a"}, 64'(counts_a), 64'h0810_2040);
    check({tag, "_counts_b"}, 64'(counts_b), 64'h8FFF);
    check({tag, "_wid"}, 64'(wid_a), 64'd1);
    check({tag, "_valid"}, 64'(valid_a), 64'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    tick(2);
    check("reset_counts", 64'({counts_a, counts_b}), 64'd0);
    check("reset_flags", 64'({valid_a, ovr_a, valid_b, ovr_b}), 64'd0);
    check("reset_wid", 64'({wid_a, wid_b}), 64'd0);
    rst_n = 1'b1;

    // Nominal window with counter-driven pulses and an always-ready consumer.
    out_ready = 1'b1;
    tick(3);
    en = 1'b1;
    tick(WINDOW + 1);
    check_nominal("nominal");
    tick(2 * WINDOW);

    // Random activity with random backpressure.
    use_ctr = 1'b0;
    rnd_ready = 1'b1;
    tick(4 * WINDOW);
    rnd_ready = 1'b0;
    use_ctr = 1'b1;

    // Backpressure across two window ends.
    out_ready = 1'b0;
    tick(2 * WINDOW + 5);
    check("bp_valid", 64'(valid_a), 64'd1);
    check("bp_overrun", 64'(ovr_a), 64'd1);
    check("bp_counts", 64'(counts_a), 64'h0810_2040);
    wait_n(10);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    check("bp_drained", 64'(valid_a), 64'd0);
    tick(3);
    check("bp_overrun_sticky", 64'(ovr_a), 64'd1);

    // Restart clears overrun, then accept exactly on a snapshot edge.
    en = 1'b0;
    tick(2);
    en = 1'b1;
    tick(1);
    check("restart_overrun_clr", 64'(ovr_a), 64'd0);
    wait_n(WINDOW - 1);
    tick(1);
    wait_n(WINDOW - 1);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    check("simul_valid", 64'(valid_a), 64'd1);
    check("simul_overrun", 64'(ovr_a), 64'd0);
    check("simul_wid", 64'(wid_a), 64'd2);

    // Abort mid-window, then re-enable.
    out_ready = 1'b1;
    wait_n(30);
    en = 1'b0;
    tick(5);
    check("abort_wid_held", 64'(wid_a), 64'd2);
    en = 1'b1;
    tick(1);
    check("abort_wid_restart", 64'(wid_a), 64'd0);
    tick(WINDOW);
    check_nominal("abort");

    // Asynchronous reset between clock edges.
    tick(20);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_counts", 64'({counts_a, counts_b}), 64'd0);
    check("areset_flags", 64'({valid_a, ovr_a, valid_b, ovr_b}), 64'd0);
    check("areset_wid", 64'({wid_a, wid_b}), 64'd0);
    tick(2);
    rst_n = 1'b1;
    tick(WINDOW + 1);
    check_nominal("post_reset");

    tick(WINDOW + 5);
    #6;
    check("queue_a_drained", 64'(exp_q_a.size()), 64'd0);
    check("queue_b_drained", 64'(exp_q_b.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
